// File: rtl/dit_div_miter.sv
// Data-independent-timing miter: two iterative restoring dividers sharing one control stream.
// Optional macro DIV_EARLY_TERM_EN enables a data-dependent early exit (negative control).

module dit_div_core #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int unsigned IW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    iter;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] rem;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    // When it fits, trial - div always fits in WIDTH bits (or div is zero and truncation keeps the dividend bits).
    always_comb begin
        trial    = {rem, quo[WIDTH-1]};
        fits     = (trial >= {1'b0, div});
        diff     = trial[WIDTH-1:0] - div;
        rem_next = fits ? diff : trial[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            iter      <= '0;
            quo       <= '0;
            div       <= '0;
            rem       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        quo      <= a;
                        div      <= b;
                        rem      <= '0;
                        iter     <= IW'(WIDTH);
                        state    <= BUSY;
                        in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    quo  <= quo_next;
                    rem  <= rem_next;
                    iter <= iter - IW'(1);
`ifdef DIV_EARLY_TERM_EN
                    // Data-dependent shortcut on the first step; quo still holds the dividend here.
                    if (iter == IW'(WIDTH) && (div == '0 || quo == '0)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        q         <= (div == '0) ? '1 : '0;
                        r         <= (div == '0) ? quo : '0;
                    end else if (iter == IW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        q         <= quo_next;
                        r         <= rem_next;
                    end
`else
                    if (iter == IW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        q         <= quo_next;
                        r         <= rem_next;
                    end
`endif
                end
                DONE: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

module dit_div_miter #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] b2,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] r2,
    output logic             dit_violation,
    output logic [CNT_W-1:0] viol_cycle,
    output logic [CNT_W-1:0] op_count
);

    logic             ready_1;
    logic             ready_2;
    logic             valid_1;
    logic             valid_2;
    logic             mismatch;
    logic [CNT_W-1:0] cycle_cnt;

    dit_div_core #(.WIDTH(WIDTH)) u_copy1 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a1),
        .b         (b1),
        .in_ready  (ready_1),
        .out_valid (valid_1),
        .q         (q1),
        .r         (r1)
    );

    dit_div_core #(.WIDTH(WIDTH)) u_copy2 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a2),
        .b         (b2),
        .in_ready  (ready_2),
        .out_valid (valid_2),
        .q         (q2),
        .r         (r2)
    );

    assign in_ready  = ready_1;
    assign out_valid = valid_1;
    assign mismatch  = (ready_1 != ready_2) | (valid_1 != valid_2);

    // Timing checker: only handshake timing is compared, never data.
    always_ff @(posedge clock) begin
        if (reset) begin
            dit_violation <= 1'b0;
            viol_cycle    <= '0;
            op_count      <= '0;
            cycle_cnt     <= '0;
        end else begin
            if (cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (mismatch && !dit_violation) begin
                dit_violation <= 1'b1;
                viol_cycle    <= cycle_cnt;
            end
            if (valid_1 && valid_2 && op_count != '1) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule
